// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: FF46-triggered OAM DMA sequencer, 160 bytes at 4 clocks each; OAM_DMA_RESTART_EN lets a write during a transfer restart it
module oam_dma_ctrl #(
  parameter int XFER_BYTES   = 160,
  parameter int SETUP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_wdata,
  output logic        reg_hit,
  output logic [7:0]  reg_rdata,
  output logic        busy,
  output logic [15:0] src_addr,
  output logic        src_rd,
  output logic        src_is_vram,
  input  logic [7:0]  src_data,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE} state_t;
  localparam logic [2:0] SLAST = 3'(SETUP_CYCLES - 1);
  localparam logic [9:0] LAST  = 10'(4 * XFER_BYTES - 1);
  state_t      state, state_n;
  logic [7:0]  ff46, page, page_n;
  logic [2:0]  scnt, scnt_n;
  logic [9:0]  cnt, cnt_n;
  logic        done_n, reg_wr;
  logic [15:0] raw;
  assign reg_wr    = cpu_wr && cpu_addr == 16'hFF46;
  assign reg_hit   = cpu_rd && cpu_addr == 16'hFF46;
  assign reg_rdata = ff46;
  assign raw       = {page, cnt[9:2]};
  // state, counters and latched page
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ff46  <= 8'h00;
      page  <= 8'h00;
      scnt  <= 3'd0;
      cnt   <= 10'd0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      ff46  <= reg_wr ? cpu_wdata : ff46;
      page  <= page_n;
      scnt  <= scnt_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  end
  // next-state sequencing and transfer-side outputs; echo/OAM pages fold down onto WRAM
  always_comb begin
    state_n     = state;
    page_n      = page;
    scnt_n      = scnt;
    cnt_n       = cnt;
    done_n      = 1'b0;
    busy        = state == ACTIVE;
    src_rd      = busy;
    oam_we      = busy && cnt[1:0] == 2'd3;
    src_addr    = busy ? (page >= 8'hE0 ? raw - 16'h2000 : raw) : 16'h0000;
    src_is_vram = src_addr[15:13] == 3'b100;
    oam_addr    = busy ? cnt[9:2] : 8'h00;
    oam_wdata   = src_data;
    if (state == SETUP) begin
      scnt_n = scnt + 3'd1;
      if (scnt == SLAST) begin
        state_n = ACTIVE;
        cnt_n   = 10'd0;
      end
    end
    if (state == ACTIVE) begin
      cnt_n = cnt + 10'd1;
      if (cnt == LAST) begin
        state_n = IDLE;
        cnt_n   = 10'd0;
        done_n  = 1'b1;
      end
    end
`ifdef OAM_DMA_RESTART_EN
    if (reg_wr) begin
      state_n = SETUP;
      page_n  = cpu_wdata;
      scnt_n  = 3'd0;
      done_n  = 1'b0;
    end
`else
    if (reg_wr && state != ACTIVE) begin
      state_n = SETUP;
      page_n  = cpu_wdata;
      scnt_n  = 3'd0;
    end
`endif
  end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: randomized self-checking bench for oam_dma_ctrl against a page/byte-level transfer model
`timescale 1ns/1ps
module tb_oam_dma_ctrl;
  logic        clk = 0, rst = 1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_wr = 0, cpu_rd = 0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        reg_hit, busy, src_rd, src_is_vram, oam_we, done;
  logic [7:0]  reg_rdata, src_data, oam_addr, oam_wdata;
  logic [15:0] src_addr;
  logic [7:0]  mem [0:65535];
  int checks = 0, failures = 0, cyc = 0;
  logic [15:0] q_src[$], e_src[$];
  logic [7:0]  q_idx[$], q_data[$], e_idx[$];
  logic        q_vram[$];
  int          q_cyc[$];
  int done_cnt = 0, rise_cnt = 0, fall_cnt = 0, rise_edge = -1, fall_edge = -1;
  logic busy_q = 0;

  oam_dma_ctrl dut (.clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_wdata(cpu_wdata), .reg_hit(reg_hit), .reg_rdata(reg_rdata), .busy(busy), .src_addr(src_addr),
    .src_rd(src_rd), .src_is_vram(src_is_vram), .src_data(src_data), .oam_addr(oam_addr),
    .oam_wdata(oam_wdata), .oam_we(oam_we), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign src_data = mem[src_addr];

  always @(negedge clk) begin
    if (oam_we) begin
      q_idx.push_back(oam_addr);
      q_src.push_back(src_addr);
      q_vram.push_back(src_is_vram);
      q_data.push_back(oam_wdata);
      q_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (busy && !busy_q) begin rise_cnt++; rise_edge = cyc; end
    if (!busy && busy_q) begin fall_cnt++; fall_edge = cyc; end
    busy_q = busy;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_src(logic [7:0] p, int n);
    int a;
    a = int'(p) * 256 + n;
    if (p >= 8'hE0) a = a - 8192;
    return a[15:0];
  endfunction

  task automatic expect_bytes(logic [7:0] p, int first, int count);
    for (int n = first; n < first + count; n++) begin
      e_src.push_back(model_src(p, n));
      e_idx.push_back(8'(n));
    end
  endtask

  task automatic clr();
    q_src.delete(); q_idx.delete(); q_vram.delete(); q_data.delete(); q_cyc.delete();
    e_src.delete(); e_idx.delete();
    done_cnt = 0; rise_cnt = 0; fall_cnt = 0; rise_edge = -1; fall_edge = -1;
  endtask

  task automatic wr(input logic [7:0] d, output int edge_n);
    @(negedge clk);
    cpu_wr = 1; cpu_addr = 16'hFF46; cpu_wdata = d;
    @(negedge clk);
    cpu_wr = 0; cpu_addr = 16'h0000;
    edge_n = cyc;
  endtask

  task automatic wait_done(string tag);
    int t = 0;
    while (done_cnt == 0 && t < 2000) begin @(negedge clk); t++; end
    chk({tag, ".done_seen"}, 32'(done_cnt > 0), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic verify(string tag);
    int bi = 0, bs = 0, bv = 0, bd = 0, bt = 0;
    logic [15:0] a;
    chk({tag, ".we_count"}, q_src.size(), e_src.size());
    for (int i = 0; i < q_src.size() && i < e_src.size(); i++) begin
      a = e_src[i];
      if (q_idx[i] !== e_idx[i]) bi++;
      if (q_src[i] !== a) bs++;
      if (q_vram[i] !== (a >= 16'h8000 && a < 16'hA000)) bv++;
      if (q_data[i] !== mem[a]) bd++;
      if (i > 0 && e_idx[i] == e_idx[i-1] + 8'd1 && q_cyc[i] - q_cyc[i-1] != 4) bt++;
    end
    chk({tag, ".oam_addr_bad"}, bi, 0);
    chk({tag, ".src_addr_bad"}, bs, 0);
    chk({tag, ".vram_bad"}, bv, 0);
    chk({tag, ".data_bad"}, bd, 0);
    chk({tag, ".spacing_bad"}, bt, 0);
  endtask

  task automatic check_timing(string tag, int e);
    chk({tag, ".rise"}, rise_edge, e + 4);
    chk({tag, ".fall"}, fall_edge, e + 644);
    chk({tag, ".first_we"}, q_cyc.size() > 0 ? q_cyc[0] : -1, e + 7);
    chk({tag, ".rise_cnt"}, rise_cnt, 1);
    chk({tag, ".done_cnt"}, done_cnt, 1);
  endtask

  task automatic run_xfer(string tag, logic [7:0] p);
    int e;
    clr();
    wr(p, e);
    expect_bytes(p, 0, 160);
    wait_done(tag);
    verify(tag);
    check_timing(tag, e);
    chk({tag, ".rdata"}, reg_rdata, p);
  endtask

  initial begin
    int e, e2, n0;
    logic [7:0] p;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.src_rd", src_rd, 0);
    chk("rst.oam_we", oam_we, 0);
    chk("rst.done", done, 0);
    chk("rst.src_addr", src_addr, 0);
    chk("rst.oam_addr", oam_addr, 0);
    chk("rst.rdata", reg_rdata, 0);
    rst = 0;
    @(negedge clk);

    run_xfer("vram", 8'h80);
    run_xfer("echo", 8'hE1);

    clr();
    wr(8'hC0, e);
    wr(8'hD0, e2);
    chk("srst.gap", e2 - e, 2);
    expect_bytes(8'hD0, 0, 160);
    wait_done("srst");
    verify("srst");
    check_timing("srst", e2);

    clr();
    wr(8'hC0, e);
    repeat (103) @(negedge clk);
    wr(8'hC8, e2);
    chk("act.wr_edge", e2, e + 105);
`ifdef OAM_DMA_RESTART_EN
    expect_bytes(8'hC0, 0, 25);
    expect_bytes(8'hC8, 0, 160);
    wait_done("act");
    verify("act");
    chk("act.rise_cnt", rise_cnt, 2);
    chk("act.fall_cnt", fall_cnt, 2);
    chk("act.done_cnt", done_cnt, 1);
    chk("act.rise", rise_edge, e2 + 4);
    chk("act.fall", fall_edge, e2 + 644);
`else
    expect_bytes(8'hC0, 0, 160);
    wait_done("act");
    verify("act");
    check_timing("act", e);
`endif
    chk("act.rdata", reg_rdata, 8'hC8);

    clr();
    p = 8'($urandom);
    wr(p, e);
    repeat (304) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mrst.busy", busy, 0);
    chk("mrst.oam_we", oam_we, 0);
    chk("mrst.rdata", reg_rdata, 0);
    chk("mrst.src_addr", src_addr, 0);
    n0 = q_src.size();
    chk("mrst.we_before", n0, 75);
    rst = 0;
    repeat (700) @(negedge clk);
    chk("mrst.we_after", q_src.size(), n0);
    chk("mrst.done_cnt", done_cnt, 0);
    chk("mrst.busy_after", busy, 0);

    clr();
    p = 8'($urandom);
    wr(p, e);
    expect_bytes(p, 0, 160);
    repeat (20) @(negedge clk);
    cpu_rd = 1; cpu_addr = 16'hFF46;
    #1;
    chk("rb.busy", busy, 1);
    chk("rb.hit", reg_hit, 1);
    chk("rb.rdata", reg_rdata, p);
    cpu_addr = 16'hFF47;
    #1;
    chk("rb.miss", reg_hit, 0);
    cpu_rd = 0; cpu_addr = 16'hFF46;
    #1;
    chk("rb.nord", reg_hit, 0);
    cpu_addr = 16'h0000;
    wait_done("rb");
    verify("rb");
    check_timing("rb", e);

    for (int k = 0; k < 3; k++) begin
      p = 8'($urandom);
      if (k == 0) p = 8'hFE;
      run_xfer($sformatf("rnd%0d", k), p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
